// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard logic.
// Register indices are zero-extended to SB_REG_MAX_W inside scoreboard entries.
package pipeline_pkg;

   localparam int unsigned STG_IF  = 0;
   localparam int unsigned STG_ID  = 1;
   localparam int unsigned STG_EX  = 2;
   localparam int unsigned STG_MEM = 3;
   localparam int unsigned STG_WB  = 4;

   // Entries carry register fields at this width; REG_W must not exceed it.
   localparam int unsigned SB_REG_MAX_W = 8;

   typedef struct packed {
      logic                    valid;
      logic [SB_REG_MAX_W-1:0] rd;
      logic [SB_REG_MAX_W-1:0] rs;
      logic [SB_REG_MAX_W-1:0] rt;
      logic                    uses_rs;
      logic                    uses_rt;
      logic                    writes;
      logic                    is_load;
   } sb_entry_t;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_t;

   // Youngest producer wins; a load still in MEM has no data yet, so it yields FWD_RF.
   function automatic fwd_sel_t pick_src(logic used, logic mem_hit, logic mem_is_load, logic wb_hit);
      pick_src = FWD_RF;
      if (used) begin
         if (mem_hit)     pick_src = mem_is_load ? FWD_RF : FWD_MEM;
         else if (wb_hit) pick_src = FWD_WB;
      end
   endfunction

endpackage

// File: rtl/sb_match.sv
// Comparator: does a scoreboard entry write register r ($0 never matches).
module sb_match
   import pipeline_pkg::*;
(
   input  sb_entry_t               entry,
   input  logic [SB_REG_MAX_W-1:0] r,
   output logic                    hit
);

   always_comb begin
      hit = entry.valid & entry.writes & (entry.rd == r) & (r != '0);
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: EX/MEM/WB entry tracking, load-use stall request,
// EX operand forwarding selects and a saturating stall-cycle counter.
module hazard_scoreboard
   import pipeline_pkg::*;
#(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       full_bits,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_writes_reg,
   input  logic             id_is_load,
   output logic             load_write_predicate,
   output logic [1:0]       fwd_rs,
   output logic [1:0]       fwd_rt,
   output logic [CNT_W-1:0] stall_count
);

   sb_entry_t               ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [CNT_W-1:0]        stall_count_q, stall_count_d;
   logic [SB_REG_MAX_W-1:0] id_rs_x, id_rt_x, id_rd_x;
   logic                    ex_hit_rs, ex_hit_rt;
   logic                    mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;
   logic                    lwp;
   fwd_sel_t                fwd_rs_sel, fwd_rt_sel;
   logic                    unused_bits;

   always_comb begin
      id_rs_x = SB_REG_MAX_W'(id_rs);
      id_rt_x = SB_REG_MAX_W'(id_rt);
      id_rd_x = SB_REG_MAX_W'(id_rd);
   end

   sb_match u_ex_rs  (.entry(ex_q),  .r(id_rs_x), .hit(ex_hit_rs));
   sb_match u_ex_rt  (.entry(ex_q),  .r(id_rt_x), .hit(ex_hit_rt));
   sb_match u_mem_rs (.entry(mem_q), .r(ex_q.rs), .hit(mem_hit_rs));
   sb_match u_mem_rt (.entry(mem_q), .r(ex_q.rt), .hit(mem_hit_rt));
   sb_match u_wb_rs  (.entry(wb_q),  .r(ex_q.rs), .hit(wb_hit_rs));
   sb_match u_wb_rt  (.entry(wb_q),  .r(ex_q.rt), .hit(wb_hit_rt));

   always_comb begin
      lwp = full_bits[STG_ID] & ex_q.is_load &
            ((id_uses_rs & ex_hit_rs) | (id_uses_rt & ex_hit_rt));
      fwd_rs_sel = pick_src(ex_q.valid & ex_q.uses_rs, mem_hit_rs, mem_q.is_load, wb_hit_rs);
      fwd_rt_sel = pick_src(ex_q.valid & ex_q.uses_rt, mem_hit_rt, mem_q.is_load, wb_hit_rt);
   end

   // A stall turns the EX slot into a bubble; ID is held upstream.
   always_comb begin
      ex_d         = '0;
      ex_d.valid   = full_bits[STG_ID] & ~lwp;
      ex_d.rd      = id_rd_x;
      ex_d.rs      = id_rs_x;
      ex_d.rt      = id_rt_x;
      ex_d.uses_rs = id_uses_rs;
      ex_d.uses_rt = id_uses_rt;
      ex_d.writes  = id_writes_reg;
      ex_d.is_load = id_is_load;
      mem_d        = ex_q;
      mem_d.valid  = ex_q.valid & full_bits[STG_EX];
      wb_d         = mem_q;
      stall_count_d = stall_count_q;
      if (lwp && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q          <= '0;
         mem_q         <= '0;
         wb_q          <= '0;
         stall_count_q <= '0;
      end else begin
         ex_q          <= ex_d;
         mem_q         <= mem_d;
         wb_q          <= wb_d;
         stall_count_q <= stall_count_d;
      end
   end

   always_comb begin
      load_write_predicate = lwp;
      fwd_rs               = fwd_rs_sel;
      fwd_rt               = fwd_rt_sel;
      stall_count          = stall_count_q;
      unused_bits = ^{full_bits[STG_IF], full_bits[STG_MEM], full_bits[STG_WB],
                      mem_q.rs, mem_q.rt, mem_q.uses_rs, mem_q.uses_rt,
                      wb_q.rs, wb_q.rt, wb_q.uses_rs, wb_q.uses_rt, wb_q.is_load};
   end

endmodule
